core_boot_ctrl: RTL and testbench
=================================

# core_boot_ctrl

Boot and run controller for the single-cycle RISC-V core. It holds the core in reset and loads a program into instruction memory from a byte stream, packing bytes little-endian into 32-bit words. It then releases the core from reset and counts run cycles until the core reaches the halt opcode, where it freezes the core. It sits between the host/loader interface, the instruction-memory write port and the core's reset input.

## Interface
- ADDR_W, 8, instruction-memory word-address width; depth = 2**ADDR_W words
- HALT_OPCODE, 7'b1110011, opcode that ends RUN (SYSTEM/ECALL)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock domain only
- start  in  1  single-cycle pulse; begins a load; honoured only in IDLE or HALT
- abort  in  1  return to IDLE from any state at the next edge
- load_len  in  ADDR_W+1  number of words to load; sampled on an accepted start
- s_valid  in  1  byte-stream valid
- s_data  in  8  byte-stream data
- s_ready  out  1  byte accepted when s_valid & s_ready at a rising edge
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_waddr  out  ADDR_W  word address
- imem_wdata  out  32  packed word
- core_reset  out  1  active-high reset to the core
- core_opcode  in  7  opcode currently decoded by the core
- busy  out  1  state is LOAD, DRAIN or RUN
- done  out  1  state is HALT
- err  out  1  sticky bad-length flag; cleared by the next accepted start
- cycle_count  out  32  number of RUN cycles executed

## Operation
- States: IDLE, LOAD, DRAIN, RUN, HALT.
- IDLE:
  - core_reset=1, s_ready=0.
  - On start, if load_len==0 or load_len>2**ADDR_W: err←1, stay in IDLE.
  - Otherwise: latch the length, clear err, word_idx and byte_idx, set cycle_count←0, go to LOAD.
- LOAD:
  - s_ready=1.
  - Each accepted byte goes into lane byte_idx of the word buffer. First byte → bits [7:0], fourth byte → [31:24].
  - On the 4th byte, at that edge: imem_we←1, imem_waddr←word_idx, imem_wdata←assembled word; word_idx++, byte_idx←0.
  - If that word was number len-1, go to DRAIN; otherwise stay in LOAD.
  - Bytes presented while s_ready=0 are not consumed.
- DRAIN: one cycle. The final write lands while core_reset is still 1 and s_ready=0. Next state is RUN.
- RUN:
  - core_reset=0; the core starts from its reset PC (0).
  - At each edge, if core_opcode==HALT_OPCODE, go to HALT. Otherwise cycle_count++, saturating at 0xFFFF_FFFF.
  - start is ignored in RUN.
- HALT:
  - core_reset=1, done=1, cycle_count holds.
  - start is handled exactly as in IDLE. A valid length reloads; an invalid one sets err and goes to IDLE.
- abort, in any state: go to IDLE at the next edge.
  - Partial bytes are discarded and imem_we is 0 at that edge.
  - cycle_count holds.
  - abort has priority over start and over byte acceptance.
- Outputs are registered or decoded from the registered state. There is no combinational path from s_valid, start or core_opcode to any output.

## Timing
- Reset values: state IDLE, core_reset=1, s_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, err=0, cycle_count=0. Internal byte_idx and word_idx are 0.
- start→LOAD: one edge. s_ready goes high in the following cycle.
- Write latency: imem_we is high in the cycle after the edge that accepted the 4th byte.
- s_ready falls in the cycle after the last byte is accepted.
- core_reset falls one cycle after the last imem_we, which is the DRAIN cycle. It rises in the cycle after the halt opcode is sampled.
- Minimum load time: 4·len accepted bytes + 1 DRAIN cycle.
- reset mid-operation: all state and outputs return to reset values immediately (asynchronous).

## Structure
- Package core_boot_pkg holds:
  - the state enum (BOOT_IDLE, BOOT_LOAD, BOOT_DRAIN, BOOT_RUN, BOOT_HALT);
  - OPC_SYSTEM = 7'b1110011, used as the HALT_OPCODE default;
  - the byte-lane constants.
- Sub-module byte_packer holds byte_idx and the 32-bit shift/lane register, and flags word_full. The FSM, counters and error logic stay in the top module.

## Test plan
- Program load: len=2, bytes 13 00 00 00 93 00 10 00 with s_valid held high.
  - Required: imem writes 0x0000_0013@0, then 0x0010_0093@1.
  - One DRAIN cycle follows, then core_reset=0.
- Backpressure: same stream with 1–3 idle cycles between bytes.
  - Required: identical writes.
  - No imem_we before each 4th byte.
  - s_ready stays 1 throughout LOAD.
- Bad length: start with len=0 → err=1, state IDLE, s_ready=0. Then start with len=257 (ADDR_W=8) → err=1. Then a valid start → err=0.
- Halt and count: in RUN, drive core_opcode=0x13 for 10 edges, then 0x73.
  - Required: done=1 and core_reset=1 in the next cycle.
  - cycle_count=10, holding.
- Abort: assert abort after 2 words + 2 bytes of a len=4 load.
  - Required: IDLE at the next edge, no further imem_we, the 2 pending bytes dropped.
  - A fresh start reloads from word 0.
- Async reset and restart:
  - Assert reset mid-RUN → all outputs take their reset values immediately, without waiting for an edge.
  - Separately, start from HALT with len=1 → done clears and word 0 is rewritten.

Source files
------------

// File: rtl/core_boot_pkg.sv
// Shared types and constants for the boot/run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_boot_pkg;

  // Controller phases: wait for a start, stream program words in, let the
  // last write settle, run the core, then park it after the halt opcode.
  typedef enum logic [2:0] {
    BOOT_IDLE,
    BOOT_LOAD,
    BOOT_DRAIN,
    BOOT_RUN,
    BOOT_HALT
  } boot_state_e;

  // SYSTEM/ECALL major opcode; reaching it ends a run.
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Byte lanes of a 32-bit little-endian instruction word.
  localparam int         LANE_W    = 8;
  localparam logic [1:0] LAST_LANE = 2'd3;

endpackage

// File: rtl/core_boot_ctrl_if.sv
// Host/loader, instruction-memory write port and core-control bundle.
// Latency: n/a (wiring only).
// Backpressure: s_valid/s_ready byte handshake; every other signal is level-based.
// Ports: master = host side (drives start/abort/load_len/stream/core_opcode),
//        slave  = core_boot_ctrl (drives s_ready, imem write port, core_reset, status).
interface core_boot_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   load_len;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic [6:0]        core_opcode;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       cycle_count;

  modport master (
    output start, abort, load_len, s_valid, s_data, core_opcode,
    input  s_ready, imem_we, imem_waddr, imem_wdata, core_reset,
           busy, done, err, cycle_count
  );

  modport slave (
    input  start, abort, load_len, s_valid, s_data, core_opcode,
    output s_ready, imem_we, imem_waddr, imem_wdata, core_reset,
           busy, done, err, cycle_count
  );
endinterface

// File: rtl/core_boot_ctrl_byte_packer.sv
// Packs accepted stream bytes little-endian into a 32-bit word.
// Latency: word_o/word_full_o are valid in the same cycle the 4th byte is accepted.
// Backpressure: none of its own; the caller qualifies accept_i with its ready.
// Ports: clk/reset, clr_i (drop partial word), accept_i + byte_i (byte taken),
//        word_full_o (this byte completes a word), word_o (assembled word).
module byte_packer
  import core_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic        word_full_o,
  output logic [31:0] word_o
);

  logic [1:0]  byte_idx_q;
  logic [31:0] lanes_q;

  // Merge the incoming byte into its lane so the completed word is
  // available at the same edge that accepts the final byte.
  always_comb begin
    word_o = lanes_q;
    word_o[{byte_idx_q, 3'b000} +: LANE_W] = byte_i;
  end

  assign word_full_o = accept_i && (byte_idx_q == LAST_LANE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx_q <= 2'd0;
      lanes_q    <= 32'd0;
    end else if (clr_i) begin
      byte_idx_q <= 2'd0;
      lanes_q    <= 32'd0;
    end else if (accept_i) begin
      lanes_q    <= word_o;
      byte_idx_q <= byte_idx_q + 2'd1;  // wraps to lane 0 after a full word
    end
  end

endmodule

// File: rtl/core_boot_ctrl.sv
// Boot/run controller: loads imem from a byte stream, releases the core, counts run cycles to halt.
// Latency: imem write one cycle after the 4th byte; one DRAIN cycle before core_reset falls.
// Backpressure: s_ready is high only in LOAD; bytes offered at other times are not consumed.
// Ports: clk, reset (async, active-high), bus (slave modport of core_boot_ctrl_if).
module core_boot_ctrl
  import core_boot_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter logic [6:0] HALT_OPCODE = OPC_SYSTEM
) (
  input  logic              clk,
  input  logic              reset,
  core_boot_ctrl_if.slave   bus
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  boot_state_e       state_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic              err_q;
  logic [31:0]       cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic              start_ok;
  logic              len_bad;
  logic              last_word;
  logic              word_full;
  logic [31:0]       word;

  // abort outranks both byte acceptance and start.
  assign accept    = (state_q == BOOT_LOAD) && bus.s_valid && !bus.abort;
  assign start_ok  = bus.start && !bus.abort &&
                     ((state_q == BOOT_IDLE) || (state_q == BOOT_HALT));
  assign len_bad   = (bus.load_len == '0) || (bus.load_len > LEN_MAX);
  assign last_word = ({1'b0, word_idx_q} == (len_q - (ADDR_W+1)'(1)));

  byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (bus.abort || start_ok),
    .accept_i    (accept),
    .byte_i      (bus.s_data),
    .word_full_o (word_full),
    .word_o      (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= 32'd0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
    end else begin
      we_q <= 1'b0;
      if (bus.abort) begin
        state_q <= BOOT_IDLE;
      end else begin
        case (state_q)
          BOOT_IDLE, BOOT_HALT: begin
            if (bus.start) begin
              if (len_bad) begin
                err_q   <= 1'b1;
                state_q <= BOOT_IDLE;
              end else begin
                len_q      <= bus.load_len;
                err_q      <= 1'b0;
                word_idx_q <= '0;
                cnt_q      <= 32'd0;
                state_q    <= BOOT_LOAD;
              end
            end
          end
          BOOT_LOAD: begin
            if (word_full) begin
              we_q       <= 1'b1;
              waddr_q    <= word_idx_q;
              wdata_q    <= word;
              word_idx_q <= word_idx_q + ADDR_W'(1);
              if (last_word) state_q <= BOOT_DRAIN;
            end
          end
          // Final write lands this cycle with the core still held.
          BOOT_DRAIN: state_q <= BOOT_RUN;
          BOOT_RUN: begin
            if (bus.core_opcode == HALT_OPCODE) begin
              state_q <= BOOT_HALT;
            end else if (cnt_q != 32'hFFFF_FFFF) begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          default: state_q <= BOOT_IDLE;
        endcase
      end
    end
  end

  assign bus.s_ready     = (state_q == BOOT_LOAD);
  assign bus.core_reset  = (state_q != BOOT_RUN);
  assign bus.busy        = (state_q == BOOT_LOAD) || (state_q == BOOT_DRAIN) ||
                           (state_q == BOOT_RUN);
  assign bus.done        = (state_q == BOOT_HALT);
  assign bus.err         = err_q;
  assign bus.cycle_count = cnt_q;
  assign bus.imem_we     = we_q;
  assign bus.imem_waddr  = waddr_q;
  assign bus.imem_wdata  = wdata_q;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Directed bench for core_boot_ctrl: load, backpressure, bad length, halt/count, abort, reset.
module tb_core_boot_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  logic [7:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  core_boot_ctrl_if #(.ADDR_W(8)) bus ();

  core_boot_ctrl #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Record every instruction-memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr_q.push_back(bus.imem_waddr);
      wr_data_q.push_back(bus.imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte and return at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (bus.s_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      nvec++;
      nerr++;
      $error("FAIL s_ready_timeout: observed 0 expected 1");
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic do_start(input logic [8:0] len);
    bus.start    = 1'b1;
    bus.load_len = len;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  logic [7:0] prog [8];

  initial begin
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.load_len    = '0;
    bus.s_valid     = 1'b0;
    bus.s_data      = 8'h00;
    bus.core_opcode = 7'h13;
    prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h10; prog[7] = 8'h00;

    // Reset values.
    @(negedge clk);
    chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("rst_s_ready",    32'(bus.s_ready),    32'd0);
    chk("rst_imem_we",    32'(bus.imem_we),    32'd0);
    chk("rst_waddr",      32'(bus.imem_waddr), 32'd0);
    chk("rst_wdata",      bus.imem_wdata,      32'd0);
    chk("rst_busy_done_err", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
    chk("rst_cycle_count", bus.cycle_count,    32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Program load, s_valid held high.
    do_start(9'd2);
    chk("load_s_ready", 32'(bus.s_ready), 32'd1);
    chk("load_busy",    32'(bus.busy),    32'd1);
    for (int i = 0; i < 8; i++) send_byte(prog[i]);
    chk("drain_imem_we",    32'(bus.imem_we),    32'd1);
    chk("drain_s_ready",    32'(bus.s_ready),    32'd0);
    chk("drain_core_reset", 32'(bus.core_reset), 32'd1);
    @(negedge clk);
    chk("run_core_reset", 32'(bus.core_reset), 32'd0);
    chk("run_count0",     bus.cycle_count,      32'd0);
    chk("load_nwrites",   32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      chk("load_w0_addr", 32'(wr_addr_q[0]), 32'd0);
      chk("load_w0_data", wr_data_q[0],      32'h0000_0013);
      chk("load_w1_addr", 32'(wr_addr_q[1]), 32'd1);
      chk("load_w1_data", wr_data_q[1],      32'h0010_0093);
    end

    // Halt and count: 10 non-halt edges, then the halt opcode.
    repeat (10) @(negedge clk);
    chk("run_count10", bus.cycle_count, 32'd10);
    bus.core_opcode = 7'h73;
    @(negedge clk);
    bus.core_opcode = 7'h13;
    chk("halt_done",       32'(bus.done),       32'd1);
    chk("halt_core_reset", 32'(bus.core_reset), 32'd1);
    chk("halt_busy",       32'(bus.busy),       32'd0);
    chk("halt_count",      bus.cycle_count,     32'd10);
    repeat (3) @(negedge clk);
    chk("halt_count_hold", bus.cycle_count,     32'd10);

    // Backpressure reload from HALT: 1-3 idle cycles between bytes.
    clear_log();
    do_start(9'd2);
    chk("bp_done_clear",  32'(bus.done),    32'd0);
    chk("bp_count_clear", bus.cycle_count,  32'd0);
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i]);
      chk($sformatf("bp_we_b%0d", i), 32'(bus.imem_we), (i % 4 == 3) ? 32'd1 : 32'd0);
      if (i != 7) begin
        repeat ((i % 3) + 1) @(negedge clk);
        chk($sformatf("bp_rdy_b%0d", i), 32'(bus.s_ready), 32'd1);
      end
    end
    chk("bp_drain_s_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    chk("bp_run_core_reset", 32'(bus.core_reset), 32'd0);
    chk("bp_nwrites", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      chk("bp_w0_addr", 32'(wr_addr_q[0]), 32'd0);
      chk("bp_w0_data", wr_data_q[0],      32'h0000_0013);
      chk("bp_w1_addr", 32'(wr_addr_q[1]), 32'd1);
      chk("bp_w1_data", wr_data_q[1],      32'h0010_0093);
    end

    // Abort out of RUN: IDLE, count holds.
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_run_busy",  32'(bus.busy),       32'd0);
    chk("abort_run_count", bus.cycle_count,     32'd3);
    chk("abort_run_creset", 32'(bus.core_reset), 32'd1);

    // Bad lengths, with valid starts in between.
    do_start(9'd0);
    chk("len0_err",     32'(bus.err),     32'd1);
    chk("len0_s_ready", 32'(bus.s_ready), 32'd0);
    chk("len0_busy",    32'(bus.busy),    32'd0);
    do_start(9'd256);
    chk("len256_err",  32'(bus.err),  32'd0);
    chk("len256_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    do_start(9'd257);
    chk("len257_err",  32'(bus.err),  32'd1);
    chk("len257_busy", 32'(bus.busy), 32'd0);

    // Abort mid-load: 2 words + 2 bytes of a len=4 load.
    clear_log();
    do_start(9'd4);
    chk("abort_ld_err_clear", 32'(bus.err), 32'd0);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
    bus.abort   = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    @(negedge clk);
    bus.abort   = 1'b0;
    bus.s_valid = 1'b0;
    chk("abort_ld_busy",    32'(bus.busy),    32'd0);
    chk("abort_ld_s_ready", 32'(bus.s_ready), 32'd0);
    chk("abort_ld_we",      32'(bus.imem_we), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_ld_nwrites", 32'(wr_addr_q.size()), 32'd2);

    // Fresh start reloads from word 0 with the partial bytes gone.
    clear_log();
    do_start(9'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(negedge clk);
    chk("reload_nwrites", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      chk("reload_addr", 32'(wr_addr_q[0]), 32'd0);
      chk("reload_data", wr_data_q[0],      32'h4433_2211);
    end
    chk("reload_run", 32'(bus.core_reset), 32'd0);
    bus.core_opcode = 7'h73;
    @(negedge clk);
    bus.core_opcode = 7'h13;
    chk("halt0_done",  32'(bus.done),   32'd1);
    chk("halt0_count", bus.cycle_count, 32'd0);

    // Restart from HALT with len=1 rewrites word 0.
    clear_log();
    do_start(9'd1);
    chk("restart_done", 32'(bus.done), 32'd0);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    @(negedge clk);
    chk("restart_nwrites", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      chk("restart_addr", 32'(wr_addr_q[0]), 32'd0);
      chk("restart_data", wr_data_q[0],      32'h0010_0093);
    end

    // Asynchronous reset mid-RUN, checked between edges.
    repeat (4) @(negedge clk);
    chk("pre_rst_count", bus.cycle_count, 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("arst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("arst_busy",       32'(bus.busy),       32'd0);
    chk("arst_done",       32'(bus.done),       32'd0);
    chk("arst_s_ready",    32'(bus.s_ready),    32'd0);
    chk("arst_count",      bus.cycle_count,     32'd0);
    chk("arst_wdata",      bus.imem_wdata,      32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
